// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// default frame width and the index-width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_WAIT = 2'b10
  } state_e;

  localparam int NB_DATA_DEF = 8;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin search: first set request at or above the
// pointer, wrapping past N_REQ-1 back to 0.
module rr_picker #(
  parameter int N_REQ  = 4,
  parameter int NB_IDX = 2
) (
  input  logic [N_REQ-1:0]  i_req,
  input  logic [NB_IDX-1:0] i_ptr,
  output logic              o_found,
  output logic [NB_IDX-1:0] o_idx
);

  // NOTE: every output gets a value before the loop so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!o_found && i_req[(int'(i_ptr) + i) % N_REQ]) begin
        o_found = 1'b1;
        o_idx   = NB_IDX'((int'(i_ptr) + i) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte producers: round-robin
// grant, one-cycle start, wait for done tick with a watchdog abort.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEF,
  parameter int N_REQ          = 4,
  parameter int NB_IDX         = clog2(N_REQ),
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int NB_TIMEOUT     = 20
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*NB_DATA-1:0] i_data,
  output logic [N_REQ-1:0]         o_ack,
  output logic [N_REQ-1:0]         o_done,
  output logic [NB_IDX-1:0]        o_grant_idx,
  output logic                     o_busy,
  output logic                     o_error,
  output logic                     o_tx_start,
  output logic [NB_DATA-1:0]       o_tx_data,
  input  logic                     i_tx_done_tick
);

  state_e                state_q, state_d;
  logic [NB_IDX-1:0]     ptr_q, ptr_d;
  logic [NB_IDX-1:0]     grant_q, grant_d;
  logic [NB_DATA-1:0]    data_q, data_d;
  logic [NB_TIMEOUT-1:0] wdog_q, wdog_d;
  logic [N_REQ-1:0]      ack_q, ack_d;
  logic [N_REQ-1:0]      done_q, done_d;
  logic                  start_q, start_d;
  logic                  busy_q, busy_d;
  logic                  error_q, error_d;

  logic                  pick_found;
  logic [NB_IDX-1:0]     pick_idx;

  rr_picker #(
    .N_REQ  (N_REQ),
    .NB_IDX (NB_IDX)
  ) u_picker (
    .i_req   (i_req),
    .i_ptr   (ptr_q),
    .o_found (pick_found),
    .o_idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    wdog_d  = wdog_q;
    error_d = error_q;
    ack_d   = '0;
    done_d  = '0;
    start_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          data_d  = i_data[int'(pick_idx)*NB_DATA +: NB_DATA];
          grant_d = pick_idx;
          ptr_d   = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
          ack_d   = N_REQ'(1) << pick_idx;
          start_d = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done tick on the timeout cycle still counts as a good frame.
        if (i_tx_done_tick) begin
          done_d  = N_REQ'(1) << grant_q;
          state_d = ST_IDLE;
        end else if (wdog_q == NB_TIMEOUT'(TIMEOUT_CYCLES - 1)) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      wdog_q  <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      wdog_q  <= wdog_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      error_q <= error_d;
    end
  end

  assign o_ack       = ack_q;
  assign o_done      = done_q;
  assign o_grant_idx = grant_q;
  assign o_busy      = busy_q;
  assign o_error     = error_q;
  assign o_tx_start  = start_q;
  assign o_tx_data   = data_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter between N_REQ byte producers (e.g. ALU result path, status/echo path).
- Accepts one byte per grant and drives the transmitter's start/data inputs.
- Waits for the transmitter's done tick before granting again.
- Includes a watchdog, so a stuck transmitter cannot lock the arbiter.

Parameters:
- NB_DATA, 8, data bits per frame; must match the transmitter.
- N_REQ, 4, number of requesters (2..8).
- NB_IDX, 2, width of the requester index; equals clog2(N_REQ).
- TIMEOUT_CYCLES, 1_000_000, maximum clocks spent in WAIT before abort.
- NB_TIMEOUT, 20, width of the watchdog counter; must hold TIMEOUT_CYCLES-1.

Ports:
- i_clk, input, 1, system clock.
- i_reset, input, 1, synchronous active-high reset.
- i_req, input, N_REQ, per-requester request level; held until the matching o_ack.
- i_data, input, N_REQ*NB_DATA, flattened bytes; requester k uses bits [k*NB_DATA +: NB_DATA].
- o_ack, output, N_REQ, one-cycle one-hot pulse: byte of requester k latched.
- o_done, output, N_REQ, one-cycle one-hot pulse: byte of requester k fully transmitted.
- o_grant_idx, output, NB_IDX, index of the current/last granted requester.
- o_busy, output, 1, high in SEND and WAIT.
- o_error, output, 1, sticky watchdog-abort flag.
- o_tx_start, output, 1, one-cycle start pulse to the transmitter.
- o_tx_data, output, NB_DATA, byte to the transmitter; stable from SEND until leaving WAIT.
- i_tx_done_tick, input, 1, transmitter end-of-stop-bit pulse.

Behaviour:
- Clock/reset: single clock i_clk. Reset is synchronous and active-high on i_reset.
- Reset values:
  - state=IDLE, rr pointer=0, watchdog=0.
  - o_ack=0, o_done=0, o_tx_start=0, o_tx_data=0, o_grant_idx=0, o_busy=0, o_error=0.
- Reset mid-frame: all state is abandoned and nothing is pulsed. The transmitter shares the reset.
- All outputs are registered; none is combinational from inputs.
- States: IDLE, SEND, WAIT.
- IDLE:
  - If any i_req bit is set, choose the first set bit searching from pointer upward and wrapping (pointer, pointer+1, ..., N_REQ-1, 0, ...).
  - Latch i_data[k] into the byte buffer, set grant_idx=k, set pointer=(k+1) mod N_REQ, go to SEND.
  - If no request, stay in IDLE.
- SEND (exactly 1 cycle):
  - o_tx_start=1, o_ack[k]=1, o_tx_data=buffer.
  - Go to WAIT; clear the watchdog.
- WAIT:
  - On i_tx_done_tick: o_done[k]=1 in the next cycle, go to IDLE.
  - Otherwise increment the watchdog.
  - When watchdog==TIMEOUT_CYCLES-1 without a done tick: set o_error, go to IDLE, no o_done pulse.
  - Done tick and timeout in the same cycle: the done tick wins and o_error is not set.
- Latency:
  - Request seen in IDLE at cycle c → o_ack and o_tx_start at c+1.
  - Done tick at cycle d → o_done and IDLE at d+1.
  - A new grant can be decided in that same IDLE cycle, giving o_tx_start at d+2.
  - Minimum spacing between starts is frame length + 2 clocks.
- i_tx_done_tick outside WAIT is ignored.
- Request dropped before being chosen: it is simply not granted; no ack.
- Requester k must deassert i_req[k] on the cycle after o_ack[k]. If still high, it is treated as a new request at the next IDLE.
- o_error clears only on reset. Arbitration continues normally after an error.
- With a single active requester, back-to-back grants go to that requester.

Decomposition:
- Shared package (uart_pkg):
  - state encoding constants ST_IDLE=2'b00, ST_SEND=2'b01, ST_WAIT=2'b10;
  - NB_DATA default;
  - the clog2 helper used for NB_IDX.
- Sub-module rr_picker: combinational. Inputs are the request vector and the pointer. Outputs are the found flag and the index. This is also the unit-test target.
- Top level holds the FSM, buffer, pointer, watchdog and output registers.

Test Plan:
- Single request: i_req=4'b0100, data2=8'hA5. Expect o_ack=4'b0100 and o_tx_start one cycle later, o_tx_data=8'hA5. A done tick 160 clocks later gives o_done=4'b0100 the next cycle.
- Round-robin: i_req=4'b1111 held with a done tick after each start. Expect grant order 0,1,2,3,0 and bytes matching i_data per index.
- Fairness after skip: pointer=1, i_req=4'b1001. Expect grant 3, then 0.
- Watchdog: TIMEOUT_CYCLES=50, one request, no done tick. Expect IDLE after 50 WAIT cycles, o_error=1, no o_done. The next request is still granted.
- Collision: done tick on exactly the timeout cycle. Expect o_done pulse and o_error stays 0.
- Reset mid-WAIT: assert i_reset for 1 cycle. Expect all outputs 0 next cycle, pointer 0; a later i_req=4'b0011 grants 0 first.
